ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage MIPS pipeline: consumes the ID/EX pipeline register outputs, applies forwarding, and performs ALU, shift and branch-compare operations. It runs an iterative multiply/divide unit with HI/LO registers, stalling the front end while busy. The EX/MEM pipeline register is built in, so all results are registered toward the MEM stage.

## Interface
Parameters:
- XLEN, 32, datapath width.
- MD_CYCLES, 32, iterations of the multiply/divide unit.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wb  in  2  WB control from ID/EX, passed through.
- m  in  3  MEM control from ID/EX, passed through.
- ex  in  4  EX control: ex[3]=reg_dst, ex[2]=alu_src, ex[1:0]=alu_op.
- pc  in  8  PC of the instruction in EX.
- instruction  in  32  opcode in [31:26], funct in [5:0].
- reg1, reg2  in  32  register-file operands.
- sign_extend  in  32  extended immediate.
- shamt  in  5  shift amount.
- rt, rd  in  5  destination candidates.
- fwd_a, fwd_b  in  2  forwarding select: 00 reg, 10 mem_fwd, 01 wb_fwd, 11 treated as 00.
- mem_fwd, wb_fwd  in  32  forwarded values.
- ex_stall  out  1  hold IF/ID/ID-EX (combinational).
- _wb  out  2  registered WB control.
- _m  out  3  registered MEM control.
- _pc  out  8  registered PC.
- _alu_result  out  32  registered ALU result.
- _write_data  out  32  registered forwarded B operand (store data).
- _dest  out  5  registered destination register.
- _zero  out  1  registered (A − B == 0).

## Operation
- A = fwd_a mux. B_reg = fwd_b mux. B = alu_src ? sign_extend : B_reg, except andi/ori use the zero-extended instruction[15:0].
- alu_op 00: add. 01: sub.
- alu_op 10 (R-type), decoded by funct:
  - 20/21 add, 22/23 sub, 24 and, 25 or, 26 xor, 27 nor.
  - 2A slt (signed), 2B sltu.
  - 00 sll, 02 srl, 03 sra; shift by shamt, operand B_reg.
  - 10 mfhi, 12 mflo.
  - 18 mult, 19 multu, 1A div, 1B divu.
  - Other funct values produce result 0.
- alu_op 11 (I-type), decoded by opcode: 08/09 add, 0C andi, 0D ori, 0E xori, 0A slti, 0B sltiu, 0F lui (imm<<16). Other opcodes produce result 0.
- Overflow is ignored; all arithmetic is modulo 2^32.
- _dest = reg_dst ? rd : rt.
- Multiply/divide FSM, states IDLE → BUSY → DONE → IDLE:
  - In IDLE, a mult/div funct with alu_op=10 latches the operands and enters BUSY.
  - BUSY runs MD_CYCLES iterations (shift-add multiply, restoring divide), then enters DONE.
  - DONE writes HI/LO and returns to IDLE.
- HI/LO results:
  - mult/multu: {HI,LO} = 64-bit product.
  - div/divu: LO = quotient, HI = remainder; signed division truncates toward zero and the remainder takes the sign of the dividend.
  - Divide by zero: LO = 0xFFFFFFFF, HI = dividend. No trap.
- ex_stall is 1 while a mult/div is in EX and the FSM is not in DONE; it is 0 otherwise.
- While ex_stall=1, the EX/MEM register loads a bubble: _wb=0, _m=0, other fields don't-care.
- When the mult/div instruction retires (DONE), it writes a bubble to EX/MEM, since its result goes only to HI/LO.
- On rst: FSM goes to IDLE, HI=LO=0, and all EX/MEM outputs are 0. An in-flight operation is abandoned with no HI/LO update.

## Timing
- ALU path latency: 1 cycle. Inputs present in cycle N appear on the registered outputs after edge N+1.
- Mult/div: the instruction enters EX at cycle 0. ex_stall=1 for cycles 0..MD_CYCLES, which is 33 cycles at the default.
- HI/LO update on the edge ending cycle MD_CYCLES+1 (DONE). In that cycle ex_stall=0, so ID/EX advances.
- An mfhi/mflo immediately following the mult/div reads the new HI/LO. HI/LO writes bypass to the mfhi/mflo read in the same cycle.
- Back-to-back mult/div: IDLE re-arms on the following cycle with no extra bubble.
- Upstream must hold ID/EX stable while ex_stall=1; operands latched at start are used regardless.

## Structure
- Shared package pipe_pkg holds:
  - funct and opcode constants;
  - alu_op encodings;
  - the fwd select encodings;
  - the md_state_t enum.
- One sub-module, mul_div_unit, contains the FSM, operand latches, iteration counter and HI/LO. It exposes start, op[1:0], busy, done, hi and lo.
- ALU decode, forwarding muxes and the EX/MEM register stay in ex_stage.

## Test plan
- add: reg1=5, reg2=7, funct 20, reg_dst=1, rd=3 → next edge: _alu_result=12, _dest=3, _wb/_m copied.
- Forwarding: fwd_a=10, mem_fwd=0xFFFFFFFF, reg2=1, slt → 1. Same operands with sltu → 0.
- Shift and immediate: sra with B_reg=0x80000000, shamt=4 → 0xF8000000. lui with imm 0x1234 → 0x12340000.
- mult with A=0xFFFFFFFF, B=2 → ex_stall high for exactly 33 cycles, bubbles on _wb/_m throughout, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. A following mflo returns 0xFFFFFFFE.
- div with A=−7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with A=9, B=0 → LO=0xFFFFFFFF, HI=9.
- Reset asserted at cycle 10 of a mult → ex_stall=0 the cycle after, HI=LO=0, all outputs 0. A subsequent add completes normally.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline: instruction field codes,
// ALU operation classes, forwarding selects and the mult/div FSM states.
package pipe_pkg;

    // ALU operation class driven by the ID stage
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

    // Forwarding selects; 2'b11 falls back to the register file value
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // R-type funct codes
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // I-type opcodes
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // mult, multu, div, divu occupy funct 0x18..0x1B
    function automatic logic is_md_funct(input logic [5:0] funct);
        return funct[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, with the sign applied when the result is written
// to HI/LO. op[1] selects divide, op[0] selects unsigned.
module mul_div_unit
    import pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(MD_CYCLES + 1);

    md_state_t         state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [2*XLEN-1:0] work_q, work_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic              is_div, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, div_shift;
    logic              div_fits;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod;
    logic [XLEN-1:0]   res_hi, res_lo;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? -v : v;
    endfunction

    // One iteration step for each operation plus the signed result fix-up
    always_comb begin
        is_div    = op_q[1];
        a_neg     = ~op_q[0] & a_q[XLEN-1];
        b_neg     = ~op_q[0] & b_q[XLEN-1];
        a_mag     = mag(a_q, ~op_q[0]);
        b_mag     = mag(b_q, ~op_q[0]);

        // Multiply: {upper, multiplier} with the multiplicand added on bit 0
        mul_sum   = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, a_mag} : '0);
        mul_next  = {mul_sum, work_q[XLEN-1:1]};

        // Divide: {remainder, quotient} shifted left, divisor subtracted when it fits
        div_shift = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
        div_fits  = div_shift >= {1'b0, b_mag};
        div_diff  = div_shift[XLEN-1:0] - b_mag;
        div_next  = {(div_fits ? div_diff : div_shift[XLEN-1:0]), work_q[XLEN-2:0], div_fits};

        prod      = (a_neg ^ b_neg) ? -work_q : work_q;
        if (!is_div) begin
            res_hi = prod[2*XLEN-1:XLEN];
            res_lo = prod[XLEN-1:0];
        end else if (b_q == '0) begin
            res_hi = a_q;
            res_lo = '1;
        end else begin
            res_hi = a_neg ? -work_q[2*XLEN-1:XLEN] : work_q[2*XLEN-1:XLEN];
            res_lo = (a_neg ^ b_neg) ? -work_q[XLEN-1:0] : work_q[XLEN-1:0];
        end
    end

    // FSM next state, operand latch and iteration control
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            MD_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    work_d  = {{XLEN{1'b0}}, (op[1] ? mag(a, ~op[0]) : mag(b, ~op[0]))};
                    cnt_d   = '0;
                    state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                work_d = is_div ? div_next : mul_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(MD_CYCLES - 1)) begin
                    state_d = MD_DONE;
                end
            end
            MD_DONE: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // Control state and architectural HI/LO registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= MD_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Operand latches and working register
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; they are always reloaded
        // on start before the FSM reads them.
        op_q   <= op_d;
        a_q    <= a_d;
        b_q    <= b_d;
        work_q <= work_d;
        cnt_q  <= cnt_d;
    end

    assign busy = (state_q == MD_BUSY);
    assign done = (state_q == MD_DONE);
    // HI/LO writes are visible to a read in the same cycle
    assign hi   = done ? res_hi : hi_q;
    assign lo   = done ? res_lo : lo_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU/shift/compare, the mult/div unit
// with its front-end stall, and the EX/MEM pipeline register.
module ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      wb,
    input  logic [2:0]      m,
    input  logic [3:0]      ex,
    input  logic [7:0]      pc,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] reg1,
    input  logic [XLEN-1:0] reg2,
    input  logic [XLEN-1:0] sign_extend,
    input  logic [4:0]      shamt,
    input  logic [4:0]      rt,
    input  logic [4:0]      rd,
    input  logic [1:0]      fwd_a,
    input  logic [1:0]      fwd_b,
    input  logic [XLEN-1:0] mem_fwd,
    input  logic [XLEN-1:0] wb_fwd,
    output logic            ex_stall,
    output logic [1:0]      _wb,
    output logic [2:0]      _m,
    output logic [7:0]      _pc,
    output logic [XLEN-1:0] _alu_result,
    output logic [XLEN-1:0] _write_data,
    output logic [4:0]      _dest,
    output logic            _zero
);

    logic            reg_dst, alu_src;
    logic [1:0]      alu_op;
    logic [5:0]      opcode, funct;
    logic [XLEN-1:0] a_op, b_reg, b_op, result;
    logic            is_md, md_busy, md_done;
    logic [XLEN-1:0] md_hi, md_lo;
    logic            unused_instr_bits;

    logic [1:0]      exm_wb_q, exm_wb_d;
    logic [2:0]      exm_m_q, exm_m_d;
    logic [7:0]      exm_pc_q, exm_pc_d;
    logic [XLEN-1:0] exm_alu_q, exm_alu_d;
    logic [XLEN-1:0] exm_wdata_q, exm_wdata_d;
    logic [4:0]      exm_dest_q, exm_dest_d;
    logic            exm_zero_q, exm_zero_d;

    assign reg_dst           = ex[3];
    assign alu_src           = ex[2];
    assign alu_op            = ex[1:0];
    assign opcode            = instruction[31:26];
    assign funct             = instruction[5:0];
    assign unused_instr_bits = ^instruction[25:16];

    // Forwarding muxes and B operand selection
    always_comb begin
        unique case (fwd_a)
            FWD_MEM: a_op = mem_fwd;
            FWD_WB:  a_op = wb_fwd;
            default: a_op = reg1;
        endcase
        unique case (fwd_b)
            FWD_MEM: b_reg = mem_fwd;
            FWD_WB:  b_reg = wb_fwd;
            default: b_reg = reg2;
        endcase
        if (!alu_src) begin
            b_op = b_reg;
        end else if (alu_op == ALU_OP_ITYPE && (opcode == OP_ANDI || opcode == OP_ORI)) begin
            b_op = {{(XLEN-16){1'b0}}, instruction[15:0]};
        end else begin
            b_op = sign_extend;
        end
    end

    // ALU decode and operation
    always_comb begin
        result = '0;
        unique case (alu_op)
            ALU_OP_ADD: result = a_op + b_op;
            ALU_OP_SUB: result = a_op - b_op;
            ALU_OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: result = a_op + b_op;
                    FN_SUB, FN_SUBU: result = a_op - b_op;
                    FN_AND:  result = a_op & b_op;
                    FN_OR:   result = a_op | b_op;
                    FN_XOR:  result = a_op ^ b_op;
                    FN_NOR:  result = ~(a_op | b_op);
                    FN_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a_op) < $signed(b_op)};
                    FN_SLTU: result = {{(XLEN-1){1'b0}}, a_op < b_op};
                    FN_SLL:  result = b_reg << shamt;
                    FN_SRL:  result = b_reg >> shamt;
                    FN_SRA:  result = XLEN'($signed(b_reg) >>> shamt);
                    FN_MFHI: result = md_hi;
                    FN_MFLO: result = md_lo;
                    default: result = '0;
                endcase
            end
            ALU_OP_ITYPE: begin
                case (opcode)
                    OP_ADDI, OP_ADDIU: result = a_op + b_op;
                    OP_ANDI:  result = a_op & b_op;
                    OP_ORI:   result = a_op | b_op;
                    OP_XORI:  result = a_op ^ b_op;
                    OP_SLTI:  result = {{(XLEN-1){1'b0}}, $signed(a_op) < $signed(b_op)};
                    OP_SLTIU: result = {{(XLEN-1){1'b0}}, a_op < b_op};
                    OP_LUI:   result = b_op << 16;
                    default:  result = '0;
                endcase
            end
            default: result = '0;
        endcase
    end

    assign is_md    = (alu_op == ALU_OP_RTYPE) && is_md_funct(funct);
    assign ex_stall = is_md && !md_done;

    mul_div_unit #(
        .XLEN      (XLEN),
        .MD_CYCLES (MD_CYCLES)
    ) u_mul_div (
        .clk   (clk),
        .rst   (rst),
        .start (is_md && !md_busy && !md_done),
        .op    (funct[1:0]),
        .a     (a_op),
        .b     (b_reg),
        .busy  (md_busy),
        .done  (md_done),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    // EX/MEM next values; a mult/div in EX always sends a bubble forward
    always_comb begin
        exm_wb_d    = is_md ? 2'b00 : wb;
        exm_m_d     = is_md ? 3'b000 : m;
        exm_pc_d    = pc;
        exm_alu_d   = result;
        exm_wdata_d = b_reg;
        exm_dest_d  = reg_dst ? rd : rt;
        exm_zero_d  = (a_op == b_op);
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            exm_wb_q    <= '0;
            exm_m_q     <= '0;
            exm_pc_q    <= '0;
            exm_alu_q   <= '0;
            exm_wdata_q <= '0;
            exm_dest_q  <= '0;
            exm_zero_q  <= 1'b0;
        end else begin
            exm_wb_q    <= exm_wb_d;
            exm_m_q     <= exm_m_d;
            exm_pc_q    <= exm_pc_d;
            exm_alu_q   <= exm_alu_d;
            exm_wdata_q <= exm_wdata_d;
            exm_dest_q  <= exm_dest_d;
            exm_zero_q  <= exm_zero_d;
        end
    end

    assign _wb          = exm_wb_q;
    assign _m           = exm_m_q;
    assign _pc          = exm_pc_q;
    assign _alu_result  = exm_alu_q;
    assign _write_data  = exm_wdata_q;
    assign _dest        = exm_dest_q;
    assign _zero        = exm_zero_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: expected EX/MEM contents are queued
// when an instruction is driven and compared after the following edge.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [7:0]  pc;
    logic [31:0] instruction, reg1, reg2, sign_extend, mem_fwd, wb_fwd;
    logic [4:0]  shamt, rt, rd;
    logic [1:0]  fwd_a, fwd_b;
    logic        ex_stall;
    logic [1:0]  o_wb;
    logic [2:0]  o_m;
    logic [7:0]  o_pc;
    logic [31:0] o_alu, o_wdata;
    logic [4:0]  o_dest;
    logic        o_zero;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [7:0]  pc;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  dest;
        logic        zero;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    ex_stage dut (
        .clk         (clk),
        .rst         (rst),
        .wb          (wb),
        .m           (m),
        .ex          (ex),
        .pc          (pc),
        .instruction (instruction),
        .reg1        (reg1),
        .reg2        (reg2),
        .sign_extend (sign_extend),
        .shamt       (shamt),
        .rt          (rt),
        .rd          (rd),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .mem_fwd     (mem_fwd),
        .wb_fwd      (wb_fwd),
        .ex_stall    (ex_stall),
        ._wb         (o_wb),
        ._m          (o_m),
        ._pc         (o_pc),
        ._alu_result (o_alu),
        ._write_data (o_wdata),
        ._dest       (o_dest),
        ._zero       (o_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // R-type with register operands, reg_dst=1
    task automatic set_r(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        ex          = 4'b1010;
        instruction = {26'd0, f};
        reg1        = a;
        reg2        = b;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        pc          = pc + 8'd4;
    endtask

    // I-type with immediate operand, reg_dst=0
    task automatic set_i(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] imm);
        ex          = 4'b0111;
        instruction = {opc, 10'd0, imm[15:0]};
        sign_extend = imm;
        reg1        = a;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        pc          = pc + 8'd4;
    endtask

    task automatic push_exp(input logic [31:0] alu, input logic [31:0] wdata,
                            input logic [4:0] dest, input logic zero);
        exp_t e;
        e.wb    = wb;
        e.m     = m;
        e.pc    = pc;
        e.alu   = alu;
        e.wdata = wdata;
        e.dest  = dest;
        e.zero  = zero;
        sb_q.push_back(e);
    endtask

    task automatic tick_check(input string name);
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            if ({o_wb, o_m, o_pc, o_alu, o_wdata, o_dest, o_zero} !== e) begin
                errors++;
                $display("FAIL %s: got wb=%h m=%h pc=%h alu=%h wd=%h dest=%0d z=%b, expected wb=%h m=%h pc=%h alu=%h wd=%h dest=%0d z=%b",
                         name, o_wb, o_m, o_pc, o_alu, o_wdata, o_dest, o_zero,
                         e.wb, e.m, e.pc, e.alu, e.wdata, e.dest, e.zero);
            end
        end
    endtask

    // Issue a mult/div and follow it through stall, bubbles and retirement
    task automatic run_md(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        int bub_bad = 0;
        set_r(f, a, b);
        wb = 2'b11;
        m  = 3'b111;
        #1;
        while (ex_stall === 1'b1 && n < 100) begin
            n++;
            @(posedge clk);
            #1;
            if (o_wb !== 2'b00 || o_m !== 3'b000) bub_bad++;
        end
        checks++;
        if (n != 33) begin
            errors++;
            $display("FAIL %s stall length: got %0d cycles, expected 33", name, n);
        end
        checks++;
        if (bub_bad != 0) begin
            errors++;
            $display("FAIL %s stall bubbles: %0d cycles with nonzero wb/m, expected 0", name, bub_bad);
        end
        @(posedge clk);
        #1;
        checks++;
        if (o_wb !== 2'b00 || o_m !== 3'b000) begin
            errors++;
            $display("FAIL %s retire bubble: got wb=%h m=%h, expected 0/0", name, o_wb, o_m);
        end
    endtask

    task automatic read_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        set_r(6'h12, 32'd0, 32'd0);
        wb = 2'b01;
        m  = 3'b000;
        push_exp(exp_lo, 32'd0, rd, 1'b1);
        tick_check({name, " mflo"});
        set_r(6'h10, 32'd0, 32'd0);
        push_exp(exp_hi, 32'd0, rd, 1'b1);
        tick_check({name, " mfhi"});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wb = 2'b11; m = 3'b111; ex = 4'b1010; pc = 8'h10;
        instruction = {26'd0, 6'h20};
        reg1 = 32'd1; reg2 = 32'd2; sign_extend = 32'd0; mem_fwd = 32'd0; wb_fwd = 32'd0;
        shamt = 5'd0; rt = 5'd9; rd = 5'd3; fwd_a = 2'b00; fwd_b = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o_wb, o_m, o_pc, o_alu, o_wdata, o_dest, o_zero} !== 83'd0) begin
            errors++;
            $display("FAIL reset outputs: got wb=%h m=%h pc=%h alu=%h wd=%h dest=%0d z=%b, expected all 0",
                     o_wb, o_m, o_pc, o_alu, o_wdata, o_dest, o_zero);
        end
        checks++;
        if (ex_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset stall: got %b, expected 0", ex_stall);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        set_r(6'h20, 32'd5, 32'd7); wb = 2'b10; m = 3'b101;
        push_exp(32'd12, 32'd7, 5'd3, 1'b0);              tick_check("add");
        set_r(6'h20, 32'd1, 32'd2); ex = 4'b0010;
        push_exp(32'd3, 32'd2, 5'd9, 1'b0);               tick_check("add dest rt");
        set_r(6'h27, 32'h0F0F0F0F, 32'h00FF00FF);
        push_exp(32'hF000F000, 32'h00FF00FF, 5'd3, 1'b0); tick_check("nor");
        set_r(6'h3F, 32'd5, 32'd7);
        push_exp(32'd0, 32'd7, 5'd3, 1'b0);               tick_check("unknown funct");
        set_r(6'h00, 32'd9, 32'd9); ex = 4'b0001;
        push_exp(32'd0, 32'd9, 5'd9, 1'b1);               tick_check("alu_op sub zero");
    endtask

    task automatic test_forwarding();
        set_r(6'h2A, 32'd100, 32'd1); fwd_a = 2'b10; mem_fwd = 32'hFFFFFFFF;
        push_exp(32'd1, 32'd1, 5'd3, 1'b0);               tick_check("slt mem fwd");
        set_r(6'h2B, 32'd100, 32'd1); fwd_a = 2'b10;
        push_exp(32'd0, 32'd1, 5'd3, 1'b0);               tick_check("sltu mem fwd");
        set_r(6'h20, 32'd3, 32'd77); fwd_b = 2'b01; wb_fwd = 32'd10;
        push_exp(32'd13, 32'd10, 5'd3, 1'b0);             tick_check("add wb fwd");
        set_r(6'h22, 32'd4, 32'd4); fwd_a = 2'b11; mem_fwd = 32'd99; wb_fwd = 32'd55;
        push_exp(32'd0, 32'd4, 5'd3, 1'b1);               tick_check("fwd 11 is reg");
    endtask

    task automatic test_shift_imm();
        set_r(6'h03, 32'd0, 32'h80000000); shamt = 5'd4;
        push_exp(32'hF8000000, 32'h80000000, 5'd3, 1'b0); tick_check("sra");
        set_r(6'h02, 32'd0, 32'h80000000); shamt = 5'd4;
        push_exp(32'h08000000, 32'h80000000, 5'd3, 1'b0); tick_check("srl");
        set_r(6'h00, 32'd1, 32'd1); shamt = 5'd31;
        push_exp(32'h80000000, 32'd1, 5'd3, 1'b1);        tick_check("sll 31");
        reg2 = 32'd55;
        set_i(6'h0F, 32'd0, 32'h00001234);
        push_exp(32'h12340000, 32'd55, 5'd9, 1'b0);       tick_check("lui");
        set_i(6'h0C, 32'hFFFFFFFF, 32'hFFFFF0F0);
        push_exp(32'h0000F0F0, 32'd55, 5'd9, 1'b0);       tick_check("andi zext");
        set_i(6'h23, 32'd5, 32'd5);
        push_exp(32'd0, 32'd55, 5'd9, 1'b1);              tick_check("unknown opcode");
        set_i(6'h23, 32'd100, 32'hFFFFFFFC); ex = 4'b0100;
        push_exp(32'd96, 32'd55, 5'd9, 1'b0);             tick_check("alu_op add imm");
    endtask

    task automatic test_muldiv();
        run_md("mult", 6'h18, 32'hFFFFFFFF, 32'd2);
        read_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_md("multu", 6'h19, 32'd3, 32'd4);
        run_md("div back-to-back", 6'h1A, 32'hFFFFFFF9, 32'd2);
        read_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("divu by zero", 6'h1B, 32'd9, 32'd0);
        read_hilo("divu by zero", 32'd9, 32'hFFFFFFFF);
    endtask

    task automatic test_reset_mid_mult();
        set_r(6'h18, 32'd1234, 32'd5678);
        wb = 2'b11; m = 3'b111;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        set_r(6'h20, 32'd5, 32'd7);
        @(posedge clk);
        #1;
        checks++;
        if (ex_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset mid-mult stall: got %b, expected 0", ex_stall);
        end
        checks++;
        if ({o_wb, o_m, o_pc, o_alu, o_wdata, o_dest, o_zero} !== 83'd0) begin
            errors++;
            $display("FAIL reset mid-mult outputs: got wb=%h m=%h alu=%h, expected all 0", o_wb, o_m, o_alu);
        end
        rst = 1'b0;
        wb = 2'b10; m = 3'b001;
        push_exp(32'd12, 32'd7, 5'd3, 1'b0);
        tick_check("add after reset");
        read_hilo("after reset", 32'd0, 32'd0);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_forwarding();
        test_shift_imm();
        test_muldiv();
        test_reset_mid_mult();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
